// File: rtl/gpmc_pkg.sv
// Shared definitions for the asynchronous GPMC controller.
//   gpmc_state_e : access sequencer states
//   SPACE_*      : chip-select space encoding (NCS4 = data, NCS6 = control)
//   CNT_MAX      : saturation value of the overrun/underrun counters
//   sat_inc      : saturating 16-bit increment
package gpmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACT    = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_RD_ACT    = 3'd3,
    ST_RD_DONE   = 3'd4
  } gpmc_state_e;

  localparam logic SPACE_DATA = 1'b0;
  localparam logic SPACE_CTRL = 1'b1;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gpmc_sync.sv
// Multi-flop synchroniser for the GPMC select/strobe pins.
//   clk, reset : system clock, synchronous active-high reset
//   pins_i     : {NCS4, NCS6, NWE, NOE} straight from the pads (active low)
//   pins_o     : the same four pins after SYNC_STAGES flops
// Every stage resets high so the pins read as inactive until the chain refills.
module gpmc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pins_i,
  output logic [3:0] pins_o
);

  logic [3:0] chain_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_q[i] <= 4'hF;
      end
    end else begin
      chain_q[0] <= pins_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign pins_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpmc_async_ctrl.sv
// FPGA-side controller for the asynchronous GPMC bus.
//   clk, reset            : system clock, synchronous active-high reset
//   EM_A[10:1], EM_D_in   : address / write data from the pads
//   EM_D_out, EM_D_oe     : read data / output enable to the pads
//   EM_NCS4, EM_NCS6      : data / control chip selects (active low)
//   EM_NWE, EM_NOE        : write / read strobes (active low)
//   tx_*                  : data-space writes towards the TX FIFO
//   rx_*                  : data-space reads from the RX FIFO (prefetched)
//   set_stb/addr/data     : 32-bit settings-bus writes built from two control writes
//   rb_addr, rb_data      : control-space readback
//   overrun_cnt           : TX words dropped (saturating)
//   underrun_cnt          : data reads that found the prefetch empty (saturating)
//
// Handshakes: a word moves on tx_* in the single cycle tx_src_rdy is high, and
// only if tx_dst_rdy is high in that same cycle; otherwise it is dropped. The
// RX side is a pop strobe: rx_data is sampled while rx_src_rdy is high and
// rx_dst_rdy pulses for one cycle on the next cycle to remove that word.
module gpmc_async_ctrl
  import gpmc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RB_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:1]         EM_A,
  input  logic [15:0]         EM_D_in,
  output logic [15:0]         EM_D_out,
  output logic                EM_D_oe,
  input  logic                EM_NCS4,
  input  logic                EM_NCS6,
  input  logic                EM_NWE,
  input  logic                EM_NOE,
  output logic [15:0]         tx_data,
  output logic                tx_src_rdy,
  input  logic                tx_dst_rdy,
  input  logic [15:0]         rx_data,
  input  logic                rx_src_rdy,
  output logic                rx_dst_rdy,
  output logic                set_stb,
  output logic [7:0]          set_addr,
  output logic [31:0]         set_data,
  output logic [7:0]          rb_addr,
  input  logic [RB_WIDTH-1:0] rb_data,
  output logic [15:0]         overrun_cnt,
  output logic [15:0]         underrun_cnt
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  // Synchronised pins and decoded activity
  logic [3:0] pins_s;
  logic       ncs4_s, ncs6_s, nwe_s, noe_s;
  logic       wr_act, rd_act, space_now;

  gpmc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pins_i ({EM_NCS4, EM_NCS6, EM_NWE, EM_NOE}),
    .pins_o (pins_s)
  );

  assign {ncs4_s, ncs6_s, nwe_s, noe_s} = pins_s;
  assign wr_act    = ~(ncs4_s & ncs6_s) & ~nwe_s;
  assign rd_act    = ~(ncs4_s & ncs6_s) & ~noe_s;
  assign space_now = ~ncs6_s;

  // The pad driver does not wait for the synchroniser.
  assign EM_D_oe = ~EM_NOE & ~(EM_NCS4 & EM_NCS6);

  // State and registers
  gpmc_state_e         state_q;
  logic                space_q;
  logic                armed_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [10:1]         wr_addr_q;
  logic [15:0]         wr_data_q;
  logic [15:0]         low_half_q;
  logic                tx_src_rdy_q;
  logic                set_stb_q;
  logic [7:0]          set_addr_q;
  logic [31:0]         set_data_q;
  logic [7:0]          rb_addr_q;
  logic [15:0]         em_d_out_q;
  logic                pf_valid_q;
  logic [15:0]         pf_data_q;
  logic                rx_dst_rdy_q;
  logic [15:0]         overrun_q;
  logic [15:0]         underrun_q;

  logic        settled;
  logic        start_wr, start_rd;
  logic        data_rd_busy;
  logic        pf_load;
  logic [31:0] rb_word;

  // After reset the synchroniser holds its reset value for SYNC_STAGES cycles;
  // only after that do the synced pins reflect the real bus, so the "wait for
  // idle bus" check must not be satisfied by the reset value of the chain.
  assign settled  = (settle_q == SETTLE_W'(SYNC_STAGES));
  assign start_wr = (state_q == ST_IDLE) && armed_q && wr_act;
  assign start_rd = (state_q == ST_IDLE) && armed_q && !wr_act && rd_act;

  // A data-space read owns the prefetch register from its start to RD_DONE,
  // so the pad value cannot change and an empty register stays empty.
  assign data_rd_busy =
      (((state_q == ST_RD_ACT) || (state_q == ST_RD_DONE)) && (space_q == SPACE_DATA)) ||
      (start_rd && (space_now == SPACE_DATA));
  assign pf_load = !pf_valid_q && rx_src_rdy && !data_rd_busy;

  assign rb_word = 32'(rb_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      space_q      <= SPACE_DATA;
      armed_q      <= 1'b0;
      settle_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      low_half_q   <= '0;
      tx_src_rdy_q <= 1'b0;
      set_stb_q    <= 1'b0;
      set_addr_q   <= '0;
      set_data_q   <= '0;
      rb_addr_q    <= '0;
      em_d_out_q   <= '0;
      pf_valid_q   <= 1'b0;
      pf_data_q    <= '0;
      rx_dst_rdy_q <= 1'b0;
      overrun_q    <= '0;
      underrun_q   <= '0;
    end else begin
      tx_src_rdy_q <= 1'b0;
      set_stb_q    <= 1'b0;
      rx_dst_rdy_q <= 1'b0;

      if (!settled) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end

      if (pf_load) begin
        pf_valid_q   <= 1'b1;
        pf_data_q    <= rx_data;
        rx_dst_rdy_q <= 1'b1;
      end

      // Data-space pad value; overridden below during a control read.
      em_d_out_q <= pf_valid_q ? pf_data_q : 16'h0000;

      case (state_q)
        ST_IDLE: begin
          rb_addr_q <= EM_A[9:2];
          if (!armed_q) begin
            if (settled && !wr_act && !rd_act) begin
              armed_q <= 1'b1;
            end
          end else if (wr_act) begin
            state_q <= ST_WR_ACT;
            space_q <= space_now;
          end else if (rd_act) begin
            state_q <= ST_RD_ACT;
            space_q <= space_now;
            if ((space_now == SPACE_DATA) && !pf_valid_q) begin
              underrun_q <= sat_inc(underrun_q);
            end
          end
        end

        ST_WR_ACT: begin
          // Keep sampling: the host holds A/D well past the strobe edge, so
          // the last sample before wr_act drops is the settled value.
          wr_addr_q <= EM_A;
          wr_data_q <= EM_D_in;
          if (!wr_act) begin
            state_q <= ST_WR_COMMIT;
            if (space_q == SPACE_DATA) begin
              tx_src_rdy_q <= 1'b1;
            end
          end
        end

        ST_WR_COMMIT: begin
          state_q <= ST_IDLE;
          if (space_q == SPACE_DATA) begin
            if (!tx_dst_rdy) begin
              overrun_q <= sat_inc(overrun_q);
            end
          end else if (!wr_addr_q[10]) begin
            if (!wr_addr_q[1]) begin
              low_half_q <= wr_data_q;
            end else begin
              set_stb_q  <= 1'b1;
              set_addr_q <= wr_addr_q[9:2];
              set_data_q <= {wr_data_q, low_half_q};
            end
          end
        end

        ST_RD_ACT: begin
          if (space_q == SPACE_CTRL) begin
            em_d_out_q <= EM_A[1] ? rb_word[31:16] : rb_word[15:0];
          end
          if (!rd_act) begin
            state_q <= ST_RD_DONE;
          end
        end

        ST_RD_DONE: begin
          state_q <= ST_IDLE;
          if (space_q == SPACE_DATA) begin
            pf_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign EM_D_out     = em_d_out_q;
  assign tx_data      = wr_data_q;
  assign tx_src_rdy   = tx_src_rdy_q;
  assign rx_dst_rdy   = rx_dst_rdy_q;
  assign set_stb      = set_stb_q;
  assign set_addr     = set_addr_q;
  assign set_data     = set_data_q;
  assign rb_addr      = rb_addr_q;
  assign overrun_cnt  = overrun_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_gpmc_async_ctrl.sv
// Directed bench for gpmc_async_ctrl: a table of bus accesses with
// hand-computed expectations, plus hand-written reset sequences.
module tb_gpmc_async_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic [9:0]  EM_A = '0;
  logic [15:0] EM_D_in = '0;
  logic [15:0] EM_D_out;
  logic        EM_D_oe;
  logic        EM_NCS4 = 1'b1;
  logic        EM_NCS6 = 1'b1;
  logic        EM_NWE = 1'b1;
  logic        EM_NOE = 1'b1;
  logic [15:0] tx_data;
  logic        tx_src_rdy;
  logic        tx_dst_rdy = 1'b1;
  logic [15:0] rx_data = '0;
  logic        rx_src_rdy = 1'b0;
  logic        rx_dst_rdy;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic [31:0] rb_data = 32'hDEADBEEF;
  logic [15:0] overrun_cnt;
  logic [15:0] underrun_cnt;

  gpmc_async_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .EM_A         (EM_A),
    .EM_D_in      (EM_D_in),
    .EM_D_out     (EM_D_out),
    .EM_D_oe      (EM_D_oe),
    .EM_NCS4      (EM_NCS4),
    .EM_NCS6      (EM_NCS6),
    .EM_NWE       (EM_NWE),
    .EM_NOE       (EM_NOE),
    .tx_data      (tx_data),
    .tx_src_rdy   (tx_src_rdy),
    .tx_dst_rdy   (tx_dst_rdy),
    .rx_data      (rx_data),
    .rx_src_rdy   (rx_src_rdy),
    .rx_dst_rdy   (rx_dst_rdy),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .rb_addr      (rb_addr),
    .rb_data      (rb_data),
    .overrun_cnt  (overrun_cnt),
    .underrun_cnt (underrun_cnt)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_err = 0;
  logic [15:0] exp_tx_q[$];
  logic [39:0] exp_set_q[$];
  logic [15:0] rx_fifo_q[$];
  int tx_cnt = 0;
  int set_cnt = 0;
  int pop_cnt = 0;
  logic tx_prev = 1'b0;
  logic set_prev = 1'b0;
  logic rx_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // RX FIFO model: presents its head, pops on rx_dst_rdy.
  always @(posedge clk) begin
    if (rx_dst_rdy && rx_fifo_q.size() > 0) begin
      void'(rx_fifo_q.pop_front());
    end
    #1;
    rx_src_rdy = (rx_fifo_q.size() > 0);
    if (rx_fifo_q.size() > 0) rx_data = rx_fifo_q[0];
    else rx_data = '0;
  end

  // Output monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (tx_src_rdy) begin
      tx_cnt++;
      check("tx_pulse_width", 32'(tx_prev), 32'd0);
      if (exp_tx_q.size() == 0) note_unexpected("tx_unexpected", 32'(tx_data));
      else check("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
    end
    if (set_stb) begin
      set_cnt++;
      check("set_pulse_width", 32'(set_prev), 32'd0);
      if (exp_set_q.size() == 0) begin
        note_unexpected("set_unexpected", set_data);
      end else begin
        logic [39:0] e;
        e = exp_set_q.pop_front();
        check("set_addr", 32'(set_addr), 32'(e[39:32]));
        check("set_data", set_data, e[31:0]);
      end
    end
    if (rx_dst_rdy) begin
      pop_cnt++;
      check("rx_pulse_width", 32'(rx_prev), 32'd0);
    end
    tx_prev  = tx_src_rdy;
    set_prev = set_stb;
    rx_prev  = rx_dst_rdy;
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low(input logic ctrl);
    if (ctrl) EM_NCS6 = 1'b0;
    else EM_NCS4 = 1'b0;
  endtask

  task automatic bus_write(input logic ctrl, input logic [9:0] a, input logic [15:0] d);
    EM_A = a;
    EM_D_in = d;
    cs_low(ctrl);
    cyc(1);
    EM_NWE = 1'b0;
    cyc(8);
    EM_NWE = 1'b1;
    cyc(6);
    EM_NCS4 = 1'b1;
    EM_NCS6 = 1'b1;
    cyc(8);
  endtask

  task automatic bus_read(input logic ctrl, input logic [9:0] a,
                          output logic [15:0] d, output logic oe_on, output logic oe_off);
    EM_A = a;
    cs_low(ctrl);
    cyc(1);
    EM_NOE = 1'b0;
    cyc(8);
    @(negedge clk);
    d = EM_D_out;
    oe_on = EM_D_oe;
    @(posedge clk);
    #1;
    EM_NOE = 1'b1;
    #1;
    oe_off = EM_D_oe;
    cyc(4);
    EM_NCS4 = 1'b1;
    EM_NCS6 = 1'b1;
    cyc(8);
  endtask

  // Vector table
  typedef struct {
    logic        is_rd;
    logic        ctrl;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        tx_rdy;
    logic [15:0] exp_rd;
    logic        set_v;
    logic [7:0]  set_a;
    logic [31:0] set_d;
    int          exp_sets;
    int          exp_tx;
    int          exp_ovr;
    int          exp_udr;
    int          exp_pops;
  } vec_t;

  vec_t vecs[$];

  task automatic add_wr(input logic ctrl, input logic [9:0] a, input logic [15:0] d,
                        input logic rdy, input logic sv, input logic [7:0] sa,
                        input logic [31:0] sd, input int sets, input int tx,
                        input int ovr, input int pops);
    vec_t v;
    v = '{1'b0, ctrl, a, d, rdy, 16'h0, sv, sa, sd, sets, tx, ovr, 0, pops};
    vecs.push_back(v);
  endtask

  task automatic add_rd(input logic ctrl, input logic [9:0] a, input logic [15:0] exp_rd,
                        input int sets, input int tx, input int ovr, input int udr,
                        input int pops);
    vec_t v;
    v = '{1'b1, ctrl, a, 16'h0, 1'b1, exp_rd, 1'b0, 8'h0, 32'h0, sets, tx, ovr, udr, pops};
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd_d;
    logic oe_on, oe_off;

    // Control writes: A=18 low half, A=19 commit, A[10] ignored, A=21 commit
    add_wr(1, 10'd18, 16'hF00D, 1, 0, 8'd0, 32'h0, 0, 0, 0, 1);
    add_wr(1, 10'd19, 16'h1234, 1, 1, 8'd9, 32'h1234F00D, 1, 0, 0, 1);
    add_wr(1, 10'd530, 16'h5555, 1, 0, 8'd0, 32'h0, 1, 0, 0, 1);
    add_wr(1, 10'd21, 16'h7777, 1, 1, 8'd10, 32'h7777F00D, 2, 0, 0, 1);
    // Data writes, all accepted
    add_wr(0, 10'd0, 16'h1234, 1, 0, 8'd0, 32'h0, 2, 1, 0, 1);
    add_wr(0, 10'd0, 16'h5678, 1, 0, 8'd0, 32'h0, 2, 2, 0, 1);
    add_wr(0, 10'd0, 16'h9ABC, 1, 0, 8'd0, 32'h0, 2, 3, 0, 1);
    add_wr(0, 10'd0, 16'hF00D, 1, 0, 8'd0, 32'h0, 2, 4, 0, 1);
    // Overrun: four accepted, then six dropped
    add_wr(0, 10'd0, 16'h0A01, 1, 0, 8'd0, 32'h0, 2, 5, 0, 1);
    add_wr(0, 10'd0, 16'h0A02, 1, 0, 8'd0, 32'h0, 2, 6, 0, 1);
    add_wr(0, 10'd0, 16'h0A03, 1, 0, 8'd0, 32'h0, 2, 7, 0, 1);
    add_wr(0, 10'd0, 16'h0A04, 1, 0, 8'd0, 32'h0, 2, 8, 0, 1);
    add_wr(0, 10'd0, 16'h0A05, 0, 0, 8'd0, 32'h0, 2, 9, 1, 1);
    add_wr(0, 10'd0, 16'h0A06, 0, 0, 8'd0, 32'h0, 2, 10, 2, 1);
    add_wr(0, 10'd0, 16'h0A07, 0, 0, 8'd0, 32'h0, 2, 11, 3, 1);
    add_wr(0, 10'd0, 16'h0A08, 0, 0, 8'd0, 32'h0, 2, 12, 4, 1);
    add_wr(0, 10'd0, 16'h0A09, 0, 0, 8'd0, 32'h0, 2, 13, 5, 1);
    add_wr(0, 10'd0, 16'h0A0A, 0, 0, 8'd0, 32'h0, 2, 14, 6, 1);
    // Control reads of DEADBEEF: FIFO pop count stays at 1
    add_rd(1, 10'd18, 16'hBEEF, 2, 14, 6, 0, 1);
    add_rd(1, 10'd19, 16'hDEAD, 2, 14, 6, 0, 1);
    // Data reads through the prefetch register, 4th one underruns
    add_rd(0, 10'd0, 16'hAAAA, 2, 14, 6, 0, 2);
    add_rd(0, 10'd0, 16'hBBBB, 2, 14, 6, 0, 3);
    add_rd(0, 10'd0, 16'hCCCC, 2, 14, 6, 0, 3);
    add_rd(0, 10'd0, 16'h0000, 2, 14, 6, 1, 3);

    rx_fifo_q.push_back(16'hAAAA);
    rx_fifo_q.push_back(16'hBBBB);
    rx_fifo_q.push_back(16'hCCCC);

    // Reset values
    cyc(4);
    @(negedge clk);
    check("rst_em_d_out", 32'(EM_D_out), 32'h0);
    check("rst_em_d_oe", 32'(EM_D_oe), 32'h0);
    check("rst_tx_src_rdy", 32'(tx_src_rdy), 32'h0);
    check("rst_rx_dst_rdy", 32'(rx_dst_rdy), 32'h0);
    check("rst_set_stb", 32'(set_stb), 32'h0);
    check("rst_set_addr", 32'(set_addr), 32'h0);
    check("rst_set_data", set_data, 32'h0);
    check("rst_rb_addr", 32'(rb_addr), 32'h0);
    check("rst_overrun", 32'(overrun_cnt), 32'h0);
    check("rst_underrun", 32'(underrun_cnt), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(10);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (!v.is_rd) begin
        tx_dst_rdy = v.tx_rdy;
        if (!v.ctrl) exp_tx_q.push_back(v.data);
        if (v.set_v) exp_set_q.push_back({v.set_a, v.set_d});
        bus_write(v.ctrl, v.addr, v.data);
        tx_dst_rdy = 1'b1;
      end else begin
        bus_read(v.ctrl, v.addr, rd_d, oe_on, oe_off);
        check($sformatf("rd_data[%0d]", i), 32'(rd_d), 32'(v.exp_rd));
        check($sformatf("oe_during_rd[%0d]", i), 32'(oe_on), 32'h1);
        check($sformatf("oe_after_noe[%0d]", i), 32'(oe_off), 32'h0);
        if (v.ctrl) check($sformatf("rb_addr[%0d]", i), 32'(rb_addr), 32'(v.addr[8:1]));
      end
      check($sformatf("set_cnt[%0d]", i), set_cnt, v.exp_sets);
      check($sformatf("tx_cnt[%0d]", i), tx_cnt, v.exp_tx);
      check($sformatf("overrun[%0d]", i), 32'(overrun_cnt), v.exp_ovr);
      check($sformatf("underrun[%0d]", i), 32'(underrun_cnt), v.exp_udr);
      check($sformatf("pops[%0d]", i), pop_cnt, v.exp_pops);
    end

    // Reset in the middle of a data write, strobe still low at release
    EM_A = 10'd0;
    EM_D_in = 16'hABCD;
    EM_NCS4 = 1'b0;
    cyc(1);
    EM_NWE = 1'b0;
    cyc(5);
    @(negedge clk);
    check("oe_during_wr", 32'(EM_D_oe), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(8);
    EM_NWE = 1'b1;
    cyc(6);
    EM_NCS4 = 1'b1;
    cyc(8);
    check("abort_tx_cnt", tx_cnt, 14);
    check("abort_overrun", 32'(overrun_cnt), 32'h0);
    check("abort_underrun", 32'(underrun_cnt), 32'h0);
    check("abort_pops", pop_cnt, 3);

    // Next full write commits normally
    exp_tx_q.push_back(16'h5A5A);
    bus_write(1'b0, 10'd0, 16'h5A5A);
    check("post_rst_tx_cnt", tx_cnt, 15);
    check("post_rst_overrun", 32'(overrun_cnt), 32'h0);

    check("exp_tx_q_empty", exp_tx_q.size(), 0);
    check("exp_set_q_empty", exp_set_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
